// File: rtl/motor_pkg.sv
// Shared types and constants for the motor ramp controller.
package motor_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_BRAKE,
        ST_REPORT1,
        ST_REPORT2
    } state_e;

    // Channel tags
    localparam logic [3:0] TAG_STOP  = 4'h0;
    localparam logic [3:0] TAG_LIMIT = 4'hE;
    localparam logic [3:0] TAG_OVF   = 4'hF;
    localparam logic [3:0] TAG_MWR   = 4'h1;
    localparam logic [3:0] TAG_ST_D1 = 4'hD;
    localparam logic [3:0] TAG_ST_D2 = 4'hC;

    // Field widths
    localparam int CTRL_W = 4;
    localparam int DATA_W = 24;
    localparam int PWM_W  = 11;
    localparam int CNT_W  = 12;

    // Motor write payload layout, shared by drive commands and motor writes
    typedef struct packed {
        logic             dir2;
        logic [PWM_W-1:0] pwm2;
        logic             dir1;
        logic [PWM_W-1:0] pwm1;
    } mdata_t;

endpackage

// File: rtl/ramp_axis.sv
// One-axis ramp step: moves a PWM magnitude/direction one STEP toward its target.
module ramp_axis
    import motor_pkg::*;
#(
    parameter int STEP = 16
) (
    input  logic [PWM_W-1:0] mag,
    input  logic             dir,
    input  logic [PWM_W-1:0] tgt,
    input  logic             tgt_dir,
    output logic [PWM_W-1:0] mag_nxt,
    output logic             dir_nxt
);

    // One extra bit of headroom so the step can never wrap past 2047 or below 0
    localparam logic [PWM_W:0] STEP_X = (PWM_W + 1)'(STEP);

    logic [PWM_W:0] mag_x;
    logic [PWM_W:0] tgt_x;
    logic [PWM_W:0] sum_x;
    logic [PWM_W:0] dif_x;

    // Same direction: approach target, clamped. Opposite: brake to 0, flip only once at 0.
    always_comb begin
        mag_x   = {1'b0, mag};
        tgt_x   = {1'b0, tgt};
        sum_x   = mag_x + STEP_X;
        dif_x   = mag_x - STEP_X;
        mag_nxt = mag;
        dir_nxt = dir;
        if (dir == tgt_dir) begin
            if (mag_x < tgt_x) begin
                mag_nxt = (sum_x >= tgt_x) ? tgt : sum_x[PWM_W-1:0];
            end else if (mag_x > tgt_x) begin
                mag_nxt = (mag_x < STEP_X || dif_x <= tgt_x) ? tgt : dif_x[PWM_W-1:0];
            end
        end else if (mag == '0) begin
            dir_nxt = tgt_dir;
        end else begin
            mag_nxt = (mag_x <= STEP_X) ? '0 : dif_x[PWM_W-1:0];
        end
    end

endmodule

// File: rtl/motor_ramp.sv
// Two-axis motor PWM ramp controller with distance limit and status report.
module motor_ramp
    import motor_pkg::*;
#(
    parameter int TICK = 50000,
    parameter int STEP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] cmd_ctrl,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_wr,
    output logic              cmd_busy,
    output logic [CTRL_W-1:0] m_ctrl,
    output logic [DATA_W-1:0] m_data,
    output logic              m_wr,
    input  logic [CTRL_W-1:0] m_rsp_ctrl,
    input  logic [DATA_W-1:0] m_rsp_data,
    input  logic              m_rsp_wr,
    output logic [CTRL_W-1:0] st_ctrl,
    output logic [DATA_W-1:0] st_data,
    output logic              st_wr
);

    localparam int            TW        = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);

    // Saturating distance accumulate; a count never wraps the 24-bit total
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [CNT_W-1:0]  b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {{(DATA_W + 1 - CNT_W){1'b0}}, b};
        return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
    endfunction

    state_e            state_q, state_d;
    logic [PWM_W-1:0]  mag1_q, mag1_d, mag2_q, mag2_d;
    logic              dir1_q, dir1_d, dir2_q, dir2_d;
    logic [PWM_W-1:0]  tgt1_q, tgt1_d, tgt2_q, tgt2_d;
    logic              tdir1_q, tdir1_d, tdir2_q, tdir2_d;
    logic [CTRL_W-1:0] tag_q, tag_d;
    logic [DATA_W-1:0] dist1_q, dist1_d, dist2_q, dist2_d;
    logic [DATA_W-1:0] limit_q, limit_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic              pend_q, pend_d;
    logic              mwr_q, mwr_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic [CTRL_W-1:0] mctrl_q, mctrl_d;
    logic              boot_q, boot_d;

    mdata_t            cmd_f;
    mdata_t            mdata_f;
    logic [PWM_W-1:0]  step_mag1, step_mag2;
    logic              step_dir1, step_dir2;
    logic              cmd_drive, cmd_stop, cmd_limit;
    logic              tick_end, run_tick, limit_hit, rsp_take, brake_done;
    logic              boot_pulse;

    assign cmd_f      = mdata_t'(cmd_data);
    assign mdata_f    = mdata_t'(mdata_q);
    assign cmd_stop   = cmd_wr && (cmd_ctrl == TAG_STOP);
    assign cmd_limit  = cmd_wr && (cmd_ctrl == TAG_LIMIT);
    assign cmd_drive  = cmd_wr && (cmd_ctrl != TAG_STOP) && (cmd_ctrl != TAG_LIMIT)
                               && (cmd_ctrl != TAG_OVF);
    assign tick_end   = (tick_q == TICK_LAST);
    assign run_tick   = ((state_q == ST_RUN) || (state_q == ST_BRAKE)) && tick_end;
    assign limit_hit  = (limit_q != '0) && ((dist1_q >= limit_q) || (dist2_q >= limit_q));
    assign rsp_take   = pend_q && (m_rsp_ctrl != TAG_OVF);
    assign brake_done = mwr_q && (mdata_f.pwm1 == '0) && (mdata_f.pwm2 == '0);
    // Stop-the-motors write issued in the first cycle out of reset
    assign boot_pulse = boot_q && !rst;

    ramp_axis #(.STEP(STEP)) u_axis1 (
        .mag     (mag1_q),
        .dir     (dir1_q),
        .tgt     (tgt1_q),
        .tgt_dir (tdir1_q),
        .mag_nxt (step_mag1),
        .dir_nxt (step_dir1)
    );

    ramp_axis #(.STEP(STEP)) u_axis2 (
        .mag     (mag2_q),
        .dir     (dir2_q),
        .tgt     (tgt2_q),
        .tgt_dir (tdir2_q),
        .mag_nxt (step_mag2),
        .dir_nxt (step_dir2)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cmd_drive) state_d = ST_RUN;
            ST_RUN:     if (cmd_stop || limit_hit) state_d = ST_BRAKE;
            ST_BRAKE:   if (brake_done) state_d = ST_REPORT1;
            ST_REPORT1: state_d = ST_REPORT2;
            ST_REPORT2: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: busy flag and the two-word distance report
    always_comb begin
        cmd_busy = (state_q == ST_BRAKE) || (state_q == ST_REPORT1) || (state_q == ST_REPORT2);
        st_wr    = 1'b0;
        st_ctrl  = '0;
        st_data  = '0;
        if (state_q == ST_REPORT1) begin
            st_wr   = 1'b1;
            st_ctrl = TAG_ST_D1;
            st_data = dist1_q;
        end else if (state_q == ST_REPORT2) begin
            st_wr   = 1'b1;
            st_ctrl = TAG_ST_D2;
            st_data = dist2_q;
        end
    end

    // Datapath next values: tick, ramp step, targets, distance, limit
    always_comb begin
        mag1_d  = mag1_q;
        mag2_d  = mag2_q;
        dir1_d  = dir1_q;
        dir2_d  = dir2_q;
        tgt1_d  = tgt1_q;
        tgt2_d  = tgt2_q;
        tdir1_d = tdir1_q;
        tdir2_d = tdir2_q;
        tag_d   = tag_q;
        dist1_d = dist1_q;
        dist2_d = dist2_q;
        limit_d = limit_q;
        tick_d  = '0;
        pend_d  = m_rsp_wr;
        mwr_d   = 1'b0;
        mdata_d = mdata_q;
        mctrl_d = boot_q ? TAG_MWR : mctrl_q;
        boot_d  = 1'b0;

        if ((state_q == ST_RUN) || (state_q == ST_BRAKE)) begin
            tick_d = tick_end ? '0 : tick_q + TW'(1);
        end

        // Step uses the targets held this cycle, so a stop arriving now only affects later ticks
        if (run_tick) begin
            mag1_d  = step_mag1;
            mag2_d  = step_mag2;
            dir1_d  = step_dir1;
            dir2_d  = step_dir2;
            mwr_d   = 1'b1;
            mdata_d = {step_dir2, step_mag2, step_dir1, step_mag1};
            mctrl_d = TAG_MWR;
        end

        if (rsp_take) begin
            dist1_d = sat_add(dist1_q, m_rsp_data[CNT_W-1:0]);
            dist2_d = sat_add(dist2_q, m_rsp_data[2*CNT_W-1:CNT_W]);
        end

        if (cmd_limit) limit_d = cmd_data;

        case (state_q)
            ST_IDLE: begin
                if (cmd_drive) begin
                    tgt1_d  = cmd_f.pwm1;
                    tgt2_d  = cmd_f.pwm2;
                    tdir1_d = cmd_f.dir1;
                    tdir2_d = cmd_f.dir2;
                    tag_d   = cmd_ctrl;
                    dist1_d = '0;
                    dist2_d = '0;
                end
            end
            ST_RUN: begin
                if (cmd_stop || limit_hit) begin
                    tgt1_d = '0;
                    tgt2_d = '0;
                end else if (cmd_drive) begin
                    tgt1_d  = cmd_f.pwm1;
                    tgt2_d  = cmd_f.pwm2;
                    tdir1_d = cmd_f.dir1;
                    tdir2_d = cmd_f.dir2;
                    tag_d   = cmd_ctrl;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mag1_q  <= '0;
            mag2_q  <= '0;
            dir1_q  <= 1'b0;
            dir2_q  <= 1'b0;
            tgt1_q  <= '0;
            tgt2_q  <= '0;
            tdir1_q <= 1'b0;
            tdir2_q <= 1'b0;
            tag_q   <= '0;
            dist1_q <= '0;
            dist2_q <= '0;
            limit_q <= '0;
            tick_q  <= '0;
            pend_q  <= 1'b0;
            mwr_q   <= 1'b0;
            mdata_q <= '0;
            mctrl_q <= '0;
            boot_q  <= 1'b1;
        end else begin
            mag1_q  <= mag1_d;
            mag2_q  <= mag2_d;
            dir1_q  <= dir1_d;
            dir2_q  <= dir2_d;
            tgt1_q  <= tgt1_d;
            tgt2_q  <= tgt2_d;
            tdir1_q <= tdir1_d;
            tdir2_q <= tdir2_d;
            tag_q   <= tag_d;
            dist1_q <= dist1_d;
            dist2_q <= dist2_d;
            limit_q <= limit_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            mwr_q   <= mwr_d;
            mdata_q <= mdata_d;
            mctrl_q <= mctrl_d;
            boot_q  <= boot_d;
        end
    end

    assign m_wr   = mwr_q || boot_pulse;
    assign m_ctrl = boot_pulse ? TAG_MWR : mctrl_q;
    assign m_data = mdata_q;

endmodule

// File: doc/motor_ramp.md
MOTOR_RAMP -- requirements
Module: motor_ramp

Interface
REQ-001 SHALL have parameter TICK, default 50000, clocks per ramp step and motor update.
REQ-002 SHALL have parameter STEP, default 16, PWM magnitude change per tick.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cmd_ctrl, input, 4, command tag.
REQ-006 SHALL have port cmd_data, input, 24, command payload.
REQ-007 SHALL have port cmd_wr, input, 1, one-cycle command strobe.
REQ-008 SHALL have port cmd_busy, output, 1, high in BRAKE/REPORT1/REPORT2.
REQ-009 SHALL have ports m_ctrl, output, 4, and m_data, output, 24, motor write channel; payload {dir2, pwm2[10:0], dir1, pwm1[10:0]}.
REQ-010 SHALL have port m_wr, output, 1, one-cycle motor write strobe.
REQ-011 SHALL have ports m_rsp_ctrl, input, 4, and m_rsp_data, input, 24, motor response; payload {cnt2[11:0], cnt1[11:0]}.
REQ-012 SHALL have port m_rsp_wr, input, 1, motor response strobe.
REQ-013 SHALL have ports st_ctrl, output, 4, st_data, output, 24, st_wr, output, 1, status channel.

Function
REQ-014 cmd tags: 0 = stop; 1..0xD = drive, payload in m_data format, tag echoed; 0xE = distance limit, cmd_data[23:0], 0 = unlimited; 0xF = ignored.
REQ-015 States: IDLE, RUN, BRAKE, REPORT1, REPORT2.
REQ-016 IDLE + drive cmd -> RUN next cycle; load targets, latch tag, clear dist1/dist2 and tick counter.
REQ-017 RUN + drive cmd -> replace targets and tag; tick counter not restarted.
REQ-018 RUN + stop cmd, or limit reached -> BRAKE; targets forced to 0.
REQ-019 Drive/stop cmds in BRAKE/REPORT1/REPORT2 dropped; limit cmd accepted in every state, effective next cycle.
REQ-020 Tick counter 0..TICK-1, wraps, runs only in RUN/BRAKE; at TICK-1, each axis steps once and m_wr pulses for one cycle with m_ctrl = 4'h1 and the post-step values.
REQ-021 Axis step, same dir: magnitude moves toward target by STEP, clamped to target; 12-bit intermediate, no wrap past 2047 or below 0.
REQ-022 Axis step, dir differs: magnitude decreases by STEP, floor 0; dir flips to target dir only on a tick where magnitude already is 0.
REQ-023 BRAKE -> REPORT1 on the cycle after the m_wr that carries both magnitudes = 0.
REQ-024 REPORT1: st_wr = 1, st_ctrl = 4'hD, st_data = dist1; REPORT2 next cycle: st_ctrl = 4'hC, st_data = dist2; then IDLE.
REQ-025 m_rsp_wr sets a pending flag; m_rsp_ctrl/m_rsp_data sampled the following cycle; tag 0xF discarded, any other tag accepted.
REQ-026 Accepted response: dist1 += cnt1, dist2 += cnt2, zero-extended, saturating at 24'hFFFFFF; applies in all states.
REQ-027 Limit reached when limit != 0 and (dist1 >= limit or dist2 >= limit); evaluated on registered dist, one cycle after the accumulate.
REQ-028 Simultaneous accumulate and limit write: both take effect; compare on next cycle.
REQ-029 Simultaneous stop cmd and tick in RUN: tick step uses old targets; BRAKE from next cycle.

Reset
REQ-030 While rst: state IDLE; magnitudes, dirs, targets, dist1, dist2, limit, tick counter, tag = 0; cmd_busy, st_wr, m_wr = 0; m_ctrl, m_data, st_ctrl, st_data = 0.
REQ-031 First cycle after rst deasserts: one m_wr with m_data = 0, m_ctrl = 4'h1, so motors stop after mid-run reset.

Structure
REQ-032 motor_pkg SHALL hold the state enum, tag constants (STOP 0, LIMIT 0xE, OVF 0xF, MWR 1, ST_D1 0xD, ST_D2 0xC) and field widths.
REQ-033 One sub-module ramp_axis (magnitude/dir step, REQ-021/022) SHALL be instantiated twice.

Verification
REQ-034 TICK=4, STEP=16; drive tag 3, pwm1 = 40 fwd -> m_wr every 4 clk, pwm1 16, 32, 40, 40.
REQ-035 pwm1 at 40 fwd; drive dir1 reversed, target 20 -> 24, 8, 0 with dir unchanged, then dir flipped with 0, then 16, 20.
REQ-036 limit 100; responses cnt1 = 60, 50 -> BRAKE; ramp to 0; status 4'hD dist1 = 110, then 4'hC dist2.
REQ-037 Response tag 0xF with cnt1 = 0xFFF -> dist unchanged; tag 1 with cnt1 = 5 -> dist1 += 5; dist1 = FFFFFE + 5 -> FFFFFF.
REQ-038 rst mid-RUN at pwm 2047 -> outputs 0 during rst; one m_wr data 0 after release; drive cmd in BRAKE ignored, cmd_busy = 1.
